// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_deserializer_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef logic [UART_DATA_BITS-1:0] Byte_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } UartRxState_t;

   // Two-out-of-three vote used to reject single-sample noise.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_baud_tick.sv
// Oversampling tick generator: one-cycle tick every TickDiv clk cycles.
// The counter can be cleared so that the tick phase lines up with a start edge.
module uart_baud_tick #(
   parameter int ClkFrequency = 60_000_000,
   parameter int Baud         = 115200,
   parameter int Oversample   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   // Rounded division; very fast links clamp to a tick every cycle.
   localparam int TickRate    = Baud * Oversample;
   localparam int TickDivRaw  = (ClkFrequency + TickRate / 2) / TickRate;
   localparam int TickDiv     = (TickDivRaw < 1) ? 1 : TickDivRaw;
   localparam int CntW        = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TickDiv - 1);

   logic [CntW-1:0] cnt_reg;

   assign tick = (cnt_reg == CntLast);

   // Free-running divider, restarted from zero on clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clear || (cnt_reg == CntLast)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// valid/ready byte output with one-cycle frame_err and overrun pulses.
// Oversample must be even and at least 8 so the three vote samples fit in a bit.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int ClkFrequency = 60_000_000,
   parameter int Baud         = 115200,
   parameter int Oversample   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int SCntW = $clog2(Oversample);
   localparam int BitW  = $clog2(UART_DATA_BITS);
   localparam logic [SCntW-1:0] SampA    = SCntW'(Oversample / 2 - 1);
   localparam logic [SCntW-1:0] SampB    = SCntW'(Oversample / 2);
   localparam logic [SCntW-1:0] SampVote = SCntW'(Oversample / 2 + 1);
   localparam logic [SCntW-1:0] ScntLast = SCntW'(Oversample - 1);
   localparam logic [BitW-1:0]  LastBit  = BitW'(UART_DATA_BITS - 1);

   logic             sync1_reg;
   logic             rxd_s_reg;
   logic             rxd_prev_reg;
   UartRxState_t     state_reg;
   logic [SCntW-1:0] scnt_reg;
   logic [BitW-1:0]  bit_idx_reg;
   logic             samp_a_reg;
   logic             samp_b_reg;
   Byte_t            shift_reg;
   Byte_t            rx_data_reg;
   logic             rx_valid_reg;
   logic             frame_err_reg;
   logic             overrun_reg;

   logic tick;
   logic start_edge;
   logic vote;
   logic vote_point;
   logic bit_wrap;

   assign start_edge = (rxd_prev_reg == UART_IDLE_LEVEL) && (rxd_s_reg != UART_IDLE_LEVEL);
   assign vote       = majority3(samp_a_reg, samp_b_reg, rxd_s_reg);
   assign vote_point = tick && (scnt_reg == SampVote);
   assign bit_wrap   = tick && (scnt_reg == ScntLast);

   uart_baud_tick #(
      .ClkFrequency(ClkFrequency),
      .Baud        (Baud),
      .Oversample  (Oversample)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .clear((state_reg == IDLE) && start_edge),
      .tick (tick)
   );

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_reg    <= UART_IDLE_LEVEL;
         rxd_s_reg    <= UART_IDLE_LEVEL;
         rxd_prev_reg <= UART_IDLE_LEVEL;
      end else begin
         sync1_reg    <= rxd;
         rxd_s_reg    <= sync1_reg;
         rxd_prev_reg <= rxd_s_reg;
      end
   end

   // Frame state machine with sampling, shifting and the output handshake.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         scnt_reg      <= '0;
         bit_idx_reg   <= '0;
         samp_a_reg    <= 1'b0;
         samp_b_reg    <= 1'b0;
         shift_reg     <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;

         // A plain handshake retires the byte; a completion below overrides this.
         if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end

         if (tick) begin
            scnt_reg <= (scnt_reg == ScntLast) ? '0 : scnt_reg + 1'b1;
            if (scnt_reg == SampA) samp_a_reg <= rxd_s_reg;
            if (scnt_reg == SampB) samp_b_reg <= rxd_s_reg;
         end

         case (state_reg)
            IDLE: begin
               scnt_reg <= '0;
               if (start_edge) begin
                  state_reg <= START;
               end
            end
            START: begin
               if (vote_point && vote) begin
                  state_reg <= IDLE;
               end else if (bit_wrap) begin
                  state_reg   <= DATA;
                  bit_idx_reg <= '0;
               end
            end
            DATA: begin
               if (vote_point) begin
                  shift_reg <= {vote, shift_reg[UART_DATA_BITS-1:1]};
               end
               if (bit_wrap) begin
                  if (bit_idx_reg == LastBit) begin
                     state_reg <= STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end
            end
            STOP: begin
               if (vote_point) begin
                  if (vote) begin
                     // Return early so a slightly fast sender's next start edge is not missed.
                     state_reg <= IDLE;
                     if (!rx_valid_reg || rx_ready) begin
                        rx_data_reg  <= shift_reg;
                        rx_valid_reg <= 1'b1;
                     end else begin
                        overrun_reg <= 1'b1;
                     end
                  end else begin
                     frame_err_reg <= 1'b1;
                     state_reg     <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxd_s_reg == UART_IDLE_LEVEL) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
   assign rx_busy   = (state_reg != IDLE);

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receive engine: recovers 8N1 frames from the asynchronous RXD pin using 16x oversampling with majority voting.
- Presents each received byte on a valid/ready output port for the controller's RX FIFO.
- Complements the existing transmit path and is the receive half of the same 115200-baud link.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
- ClkFrequency, 60_000_000, clk frequency in Hz.
- Baud, 115200, line rate in bit/s.
- Oversample, 16, sample ticks per bit; must be even and at least 8.
- TickDiv, derived as round(ClkFrequency / (Baud*Oversample)), clk cycles per sample tick. This is a localparam; a value below 1 is clamped to 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- rxd  in  1  asynchronous serial input; the idle level is 1.
- rx_data  out  8  received byte; LSB was received first.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.
- rx_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - rx_valid, frame_err and overrun are cleared to 0; rx_data is 0x00.
  - The state goes to IDLE; the tick divider and sample counter are cleared.
  - Both synchroniser flops are set to 1.
- Input path: rxd passes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s, which adds 2 cycles of latency.
- Tick generator:
  - A counter runs from 0 to TickDiv-1; tick is high for one cycle when it wraps.
  - It runs freely, but is cleared to 0 when leaving IDLE so the start bit is phase-aligned.
- Sample counter scnt (0..Oversample-1) advances on each tick. The bit value is the majority of the samples at scnt = Oversample/2-1, Oversample/2 and Oversample/2+1.
- State machine:
  - IDLE: on a 1->0 transition of rxd_s, clear scnt and the divider, then go to START.
  - START: at the majority point, if the vote is 1 the start is false and the state returns to IDLE with no error. Otherwise continue; at scnt wrap go to DATA with bit index 0.
  - DATA: at each bit's vote, shift the result into the MSB of the shift register, LSB first. At scnt wrap, increment the index. After bit 7 wraps, go to STOP.
  - STOP, vote 1: the byte completes in the cycle after the vote. The state returns to IDLE immediately without waiting for the full stop bit, which tolerates slightly fast transmitters.
  - STOP, vote 0: pulse frame_err for one cycle, discard the byte and go to BREAK.
  - BREAK: stay until rxd_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Output handshake (byte completion):
  - If rx_valid==0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise keep the old byte, drop the new one and pulse overrun for one cycle.
- rx_valid falls in the cycle after a handshake with no new completion. rx_data stays stable while rx_valid==1.
- Latency: rx_valid rises 1 clk after the stop-bit vote tick, which is about 9.5 bit times plus 3 clk after the start edge.
- rx_ready is ignored while rx_valid==0.

Decomposition:
- Shared package additions:
  - the state enum UartRxState_t, with values IDLE, START, DATA, STOP, BREAK;
  - the UART_DATA_BITS=8 constant;
  - the UART_IDLE_LEVEL=1 constant.
  Byte_t is reused for rx_data.
- One sub-module, uart_baud_tick:
  - parameters ClkFrequency, Baud, Oversample;
  - ports clk, rst, clear, tick;
  - contains the divider and TickDiv rounding.
  The 2-flop synchroniser stays inline.

Test Plan:
- Bench setup: ClkFrequency=1_600_000, Baud=100_000, Oversample=16, giving TickDiv=1 and 16 clk per bit.
- Clean byte: drive frame 0x5A with stop=1 and hold rx_ready=1 -> rx_valid pulses for 1 cycle with rx_data=0x5A; frame_err=0 and overrun=0.
- Back-to-back with backpressure: send 0xA5 then 0x3C with rx_ready=0 -> rx_data stays 0xA5 and rx_valid stays 1. On the second completion, overrun pulses once and rx_data is still 0xA5. Raising rx_ready then drops rx_valid the next cycle.
- Simultaneous accept: assert rx_ready exactly on the completion cycle of the second byte 0x3C while 0xA5 is pending -> rx_data becomes 0x3C, rx_valid stays 1, and overrun=0.
- Glitch and framing: a 4-clk low glitch on rxd -> returns to IDLE, no rx_valid, rx_busy drops within 12 clk. Frame 0xFF with stop=0 followed by a 40-clk low -> exactly one frame_err pulse, no rx_valid, and rx_busy stays 1 until rxd returns to 1.
- Noise tolerance: 0x81 with a single-clk inversion at the centre sample of bit 3 -> rx_data=0x81 by majority vote.
- Reset mid-frame: assert rst=0 for 1 cycle during bit 4 of 0x55, then send 0xC3 -> all outputs are 0 the cycle after reset; no partial byte appears; 0xC3 is received correctly.
